// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use stall and flush bubble.
// Latency: one edge from id_* to alu_*/ex_*; forwarding and stall are combinational.
module ex_operand_stage #(
  parameter int BUS_WIDTH  = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [2:0]            id_alu_op,
  input  logic [BUS_WIDTH-1:0]  id_rs_data,
  input  logic [BUS_WIDTH-1:0]  id_rt_data,
  input  logic [BUS_WIDTH-1:0]  id_imm,
  input  logic                  id_alu_src,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [BUS_WIDTH-1:0]  mem_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [BUS_WIDTH-1:0]  wb_result,
  output logic                  stall,
  output logic [2:0]            alu_Op,
  output logic [BUS_WIDTH-1:0]  alu_A,
  output logic [BUS_WIDTH-1:0]  alu_B,
  output logic [BUS_WIDTH-1:0]  ex_store_data,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [REG_ADDR_W-1:0] ex_rd_addr
);

  typedef struct packed {
    logic                  valid;
    logic [2:0]            alu_op;
    logic [BUS_WIDTH-1:0]  rs_data;
    logic [BUS_WIDTH-1:0]  rt_data;
    logic [BUS_WIDTH-1:0]  imm;
    logic                  alu_src;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } ex_reg_t;

  ex_reg_t ex_q;
  logic    hazard;
  logic    rs_match;
  logic    rt_match;

  assign rs_match = id_uses_rs & (id_rs_addr == ex_q.rd_addr);
  assign rt_match = id_uses_rt & (id_rt_addr == ex_q.rd_addr);
  assign hazard   = ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != '0) & id_valid
                  & (rs_match | rt_match);
  assign stall    = hazard & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (flush || stall) begin
      ex_q <= '0;
    end else begin
      ex_q.valid     <= id_valid;
      ex_q.alu_op    <= id_alu_op;
      ex_q.rs_data   <= id_rs_data;
      ex_q.rt_data   <= id_rt_data;
      ex_q.imm       <= id_imm;
      ex_q.alu_src   <= id_alu_src;
      ex_q.rs_addr   <= id_rs_addr;
      ex_q.rt_addr   <= id_rt_addr;
      ex_q.rd_addr   <= id_rd_addr;
      ex_q.reg_write <= id_valid & id_reg_write;
      ex_q.mem_read  <= id_valid & id_mem_read;
      ex_q.mem_write <= id_valid & id_mem_write;
    end
  end

  // r0 never forwards: its registered data is the architectural zero.
  function automatic logic [BUS_WIDTH-1:0] fwd(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [BUS_WIDTH-1:0]  data,
    input logic                  m_we,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic [BUS_WIDTH-1:0]  m_res,
    input logic                  w_we,
    input logic [REG_ADDR_W-1:0] w_rd,
    input logic [BUS_WIDTH-1:0]  w_res
  );
    logic [BUS_WIDTH-1:0] r;
    r = data;
    if (addr != '0) begin
      if (m_we && (m_rd == addr))      r = m_res;
      else if (w_we && (w_rd == addr)) r = w_res;
    end
    return r;
  endfunction

  logic [BUS_WIDTH-1:0] rs_fwd;
  logic [BUS_WIDTH-1:0] rt_fwd;

  always_comb begin
    rs_fwd = fwd(ex_q.rs_addr, ex_q.rs_data, mem_reg_write, mem_rd_addr, mem_result,
                 wb_reg_write, wb_rd_addr, wb_result);
    rt_fwd = fwd(ex_q.rt_addr, ex_q.rt_data, mem_reg_write, mem_rd_addr, mem_result,
                 wb_reg_write, wb_rd_addr, wb_result);
  end

  assign alu_A         = rs_fwd;
  assign alu_B         = ex_q.alu_src ? ex_q.imm : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_Op        = ex_q.alu_op;
  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_rd_addr    = ex_q.rd_addr;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, forwarding priority, r0, load-use, flush, pass-through.
module tb_ex_operand_stage;
  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_alu_src, id_uses_rs, id_uses_rt;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [2:0]  id_alu_op, id_rs_addr, id_rt_addr, id_rd_addr, mem_rd_addr, wb_rd_addr;
  logic [15:0] id_rs_data, id_rt_data, id_imm, mem_result, wb_result;
  logic        mem_reg_write, wb_reg_write;
  logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [2:0]  alu_Op, ex_rd_addr;
  logic [15:0] alu_A, alu_B, ex_store_data;

  int tests  = 0;
  int failed = 0;

  ex_operand_stage #(.BUS_WIDTH(16), .REG_ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alu_src(id_alu_src),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .mem_reg_write(mem_reg_write),
    .mem_rd_addr(mem_rd_addr), .mem_result(mem_result), .wb_reg_write(wb_reg_write),
    .wb_rd_addr(wb_rd_addr), .wb_result(wb_result), .stall(stall), .alu_Op(alu_Op),
    .alu_A(alu_A), .alu_B(alu_B), .ex_store_data(ex_store_data), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_rd_addr(ex_rd_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit after it before driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [2:0] rs, input logic [15:0] rsd,
                           input logic [2:0] rt, input logic [15:0] rtd, input logic src,
                           input logic [15:0] imm, input logic [2:0] rd, input logic mr);
    id_valid = 1'b1; id_alu_op = op; id_rs_addr = rs; id_rs_data = rsd;
    id_rt_addr = rt; id_rt_data = rtd; id_alu_src = src; id_imm = imm; id_rd_addr = rd;
    id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_reg_write = 1'b1; id_mem_read = mr;
    id_mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    mem_reg_write = 1'b0; mem_rd_addr = '0; mem_result = '0;
    wb_reg_write = 1'b0; wb_rd_addr = '0; wb_result = '0;
    set_instr(3'($urandom), 3'($urandom), 16'($urandom), 3'($urandom), 16'($urandom),
              1'($urandom), 16'($urandom), 3'($urandom), 1'b1);

    // Reset held two cycles
    tick(); tick(); #1;
    chk("rst_valid", 16'(ex_valid), 16'h0);
    chk("rst_op",    16'(alu_Op),   16'h0);
    chk("rst_A",     alu_A,         16'h0);
    chk("rst_B",     alu_B,         16'h0);
    chk("rst_st",    ex_store_data, 16'h0);
    chk("rst_rd",    16'(ex_rd_addr), 16'h0);
    chk("rst_ctl",   16'({ex_reg_write, ex_mem_read, ex_mem_write}), 16'h0);
    chk("rst_stall", 16'(stall),    16'h0);

    // First instruction after release
    rst = 1'b0;
    set_instr(3'd5, 3'd1, 16'h1111, 3'd2, 16'h2222, 1'b0, 16'h0, 3'd4, 1'b0);
    tick(); #1;
    chk("first_valid", 16'(ex_valid), 16'h1);
    chk("first_op", 16'(alu_Op), 16'h5);
    chk("first_A", alu_A, 16'h1111);
    chk("first_B", alu_B, 16'h2222);
    chk("first_rd", 16'(ex_rd_addr), 16'h4);

    // MEM-over-WB priority on rs
    set_instr(3'd1, 3'd3, 16'h0001, 3'd5, 16'h0055, 1'b0, 16'h0, 3'd6, 1'b0);
    tick();
    mem_reg_write = 1'b1; mem_rd_addr = 3'd3; mem_result = 16'h1234;
    wb_reg_write = 1'b1; wb_rd_addr = 3'd3; wb_result = 16'h5678;
    #1;
    chk("fwd_mem_A", alu_A, 16'h1234);
    chk("fwd_rt_untouched", alu_B, 16'h0055);
    mem_reg_write = 1'b0; #1;
    chk("fwd_wb_A", alu_A, 16'h5678);
    wb_reg_write = 1'b0; #1;
    chk("fwd_none_A", alu_A, 16'h0001);

    // r0 is never forwarded
    set_instr(3'd3, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 16'h0, 3'd1, 1'b0);
    tick();
    mem_reg_write = 1'b1; mem_rd_addr = 3'd0; mem_result = 16'hFFFF; #1;
    chk("r0_B", alu_B, 16'h0000);
    chk("r0_A", alu_A, 16'h0000);
    set_instr(3'd3, 3'd0, 16'h0, 3'd0, 16'h0, 1'b1, 16'h0007, 3'd1, 1'b0);
    tick(); #1;
    chk("r0_imm_B", alu_B, 16'h0007);
    chk("r0_store", ex_store_data, 16'h0000);
    mem_reg_write = 1'b0;

    // Load-use on rt
    set_instr(3'd0, 3'd1, 16'h0010, 3'd0, 16'h0, 1'b1, 16'h0004, 3'd2, 1'b1);
    tick();
    set_instr(3'd2, 3'd3, 16'h0033, 3'd2, 16'hDEAD, 1'b0, 16'h0, 3'd5, 1'b0);
    id_uses_rt = 1'b0; #1;
    chk("lu_no_use_stall", 16'(stall), 16'h0);
    id_uses_rt = 1'b1; #1;
    chk("lu_stall", 16'(stall), 16'h1);
    tick(); #1;
    chk("lu_bubble_valid", 16'(ex_valid), 16'h0);
    chk("lu_bubble_op", 16'(alu_Op), 16'h0);
    chk("lu_stall_drop", 16'(stall), 16'h0);
    tick();
    wb_reg_write = 1'b1; wb_rd_addr = 3'd2; wb_result = 16'hBEEF; #1;
    chk("lu_cons_valid", 16'(ex_valid), 16'h1);
    chk("lu_cons_op", 16'(alu_Op), 16'h2);
    chk("lu_cons_B", alu_B, 16'hBEEF);
    chk("lu_cons_A", alu_A, 16'h0033);
    chk("lu_cons_stall", 16'(stall), 16'h0);
    wb_reg_write = 1'b0;

    // Flush together with a load-use hazard
    set_instr(3'd0, 3'd1, 16'h0010, 3'd0, 16'h0, 1'b1, 16'h0004, 3'd2, 1'b1);
    tick();
    set_instr(3'd6, 3'd2, 16'h0, 3'd4, 16'h0, 1'b0, 16'h0, 3'd7, 1'b0);
    id_mem_write = 1'b1; flush = 1'b1; #1;
    chk("fl_stall", 16'(stall), 16'h0);
    tick(); flush = 1'b0; #1;
    chk("fl_valid", 16'(ex_valid), 16'h0);
    chk("fl_ctl", 16'({ex_reg_write, ex_mem_write}), 16'h0);
    chk("fl_op", 16'(alu_Op), 16'h0);

    // Reset during a stall
    set_instr(3'd0, 3'd1, 16'h0010, 3'd0, 16'h0, 1'b1, 16'h0004, 3'd3, 1'b1);
    tick();
    set_instr(3'd4, 3'd3, 16'h0, 3'd1, 16'h0, 1'b0, 16'h0, 3'd5, 1'b0); #1;
    chk("rs_hz_stall", 16'(stall), 16'h1);
    rst = 1'b1; flush = 1'b1;
    tick(); rst = 1'b0; flush = 1'b0; #1;
    chk("rs_hz_valid", 16'(ex_valid), 16'h0);
    chk("rs_hz_stall_after", 16'(stall), 16'h0);

    // Pass-through of all eight opcodes
    for (int i = 0; i < 8; i++) begin
      set_instr(3'(i), 3'(i), 16'h0100 + 16'(i), 3'(7 - i), 16'h0200 + 16'(i), 1'(i),
                16'h0300 + 16'(i), 3'(i), 1'b0);
      tick(); #1;
      chk($sformatf("pt_op%0d", i), 16'(alu_Op), 16'(i));
      chk($sformatf("pt_A%0d", i), alu_A, 16'h0100 + 16'(i));
      chk($sformatf("pt_B%0d", i), alu_B, (i % 2 == 1) ? 16'h0300 + 16'(i) : 16'h0200 + 16'(i));
      chk($sformatf("pt_rd%0d", i), 16'(ex_rd_addr), 16'(i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-selection stage of the 16-bit MIPS pipeline. It sits directly upstream of the ALU and supplies its `alu_Op`, `alu_A` and `alu_B` inputs. It captures decoded instructions each cycle and resolves data hazards by forwarding results from the MEM and WB stages. It detects load-use hazards, stalls decode and inserts a bubble, and kills the in-flight instruction on a branch flush.

## Interface
- `BUS_WIDTH`, 16, datapath width
- `REG_ADDR_W`, 3, register-address width (8 registers; r0 hardwired zero)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-high
- `flush`  in  1  branch taken; kill the instruction entering EX this edge
- `id_valid`  in  1  decode slot holds a real instruction
- `id_alu_op`  in  3  ALU opcode
- `id_rs_data`, `id_rt_data`  in  BUS_WIDTH  register-file read data
- `id_imm`  in  BUS_WIDTH  immediate, already extended by decode
- `id_alu_src`  in  1  1 = B operand is immediate, 0 = rt
- `id_rs_addr`, `id_rt_addr`, `id_rd_addr`  in  REG_ADDR_W  source and destination registers
- `id_uses_rs`, `id_uses_rt`  in  1  instruction actually reads rs / rt
- `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1  control bits
- `mem_reg_write`  in  1  MEM-stage instruction writes a register
- `mem_rd_addr`  in  REG_ADDR_W  MEM-stage destination register
- `mem_result`  in  BUS_WIDTH  MEM-stage ALU result
- `wb_reg_write`  in  1  WB-stage instruction writes a register
- `wb_rd_addr`  in  REG_ADDR_W  WB-stage destination register
- `wb_result`  in  BUS_WIDTH  WB-stage writeback value
- `stall`  out  1  hold PC and IF/ID this cycle
- `alu_Op`  out  3  to ALU
- `alu_A`, `alu_B`  out  BUS_WIDTH  to ALU
- `ex_store_data`  out  BUS_WIDTH  forwarded rt, for stores
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1  registered control bits passed to EX/MEM
- `ex_rd_addr`  out  REG_ADDR_W  registered destination register

## Operation
- Pipeline register fields: valid, alu_op, rs_data, rt_data, imm, alu_src, rs_addr, rt_addr, rd_addr, reg_write, mem_read, mem_write.
- Load-use hazard (combinational):
  - Raised when `ex_valid & ex_mem_read & ex_rd_addr != 0 & id_valid`.
  - And either `id_uses_rs & id_rs_addr == ex_rd_addr` or `id_uses_rt & id_rt_addr == ex_rd_addr`.
- `stall` = hazard & ~flush.
- Register update on each rising edge, first match wins:
  - `rst`: all fields cleared.
  - `flush` or `stall`: load a bubble. valid, reg_write, mem_read and mem_write = 0; alu_op = 000; data fields = 0.
  - Otherwise: capture all `id_*` fields. If `id_valid`=0, the control bits are forced to 0.
- Forwarding for operand rs (combinational, from the registered fields). Same rule for rt:
  - Registered address = 0: use the registered data. No forwarding.
  - `mem_reg_write & mem_rd_addr == addr`: use `mem_result`. MEM has priority over WB.
  - Else `wb_reg_write & wb_rd_addr == addr`: use `wb_result`.
  - Else: use the registered data.
- Outputs:
  - `alu_A` = forwarded rs.
  - `ex_store_data` = forwarded rt.
  - `alu_B` = `imm` if alu_src = 1, else forwarded rt.
  - `alu_Op` = registered alu_op.
- Forwarding is applied even when `ex_valid`=0. Bubble outputs are harmless because all their control bits are 0.
- No arithmetic is done in this block. All data paths are BUS_WIDTH wide with no extension.

## Timing
- Latency: an instruction presented on `id_*` at edge N is on `alu_*`/`ex_*` after edge N.
- Forwarded operands settle within the same cycle as the MEM/WB inputs. There is no extra latency.
- `stall` is combinational in the cycle the hazard exists, and is asserted for exactly 1 cycle per load-use pair.
  - Decode must hold `id_*` stable while `stall`=1.
  - After the bubble, the load is in WB and its data arrives via WB forwarding.
- Reset values: `stall`=0, `alu_Op`=000, `alu_A`=`alu_B`=`ex_store_data`=0, all `ex_*` control bits=0, `ex_rd_addr`=0.
- Reset asserted mid-stall overrides both stall and flush. The next cycle shows the bubble/reset state and `stall`=0, because `ex_valid`=0.
- `flush` together with a hazard: `stall`=0 and a bubble is inserted. The killed ID instruction does not re-issue from this block.
- Back-to-back loads with a dependency stall once per dependent consumer.

## Test plan
- Reset: hold `rst` 2 cycles with random `id_*` -> all outputs 0 and `stall`=0; after release, first captured instruction appears one edge later.
- MEM forward priority:
  - Stimulus: EX holds `rs_addr`=3, `rs_data`=0x0001; `mem_rd_addr`=3, `mem_result`=0x1234, `mem_reg_write`=1; WB also targets r3 with 0x5678.
  - Required response: `alu_A`=0x1234.
  - Then deassert `mem_reg_write`: `alu_A`=0x5678.
- r0 protection: MEM writes r0 with 0xFFFF, EX `rt_addr`=0, `rt_data`=0, `alu_src`=0 -> `alu_B`=0x0000; `alu_src`=1, `imm`=0x0007 -> `alu_B`=0x0007.
- Load-use:
  - Stimulus: load r2 in EX (`ex_mem_read`=1), ID instruction uses rt=r2 with `id_uses_rt`=1.
  - Required response: `stall`=1 for one cycle, then a bubble in EX (`ex_valid`=0, `alu_Op`=000).
  - Next cycle: the consumer enters EX, `stall`=0, and `alu_B` = `wb_result`.
  - With `id_uses_rt`=0 the same stimulus gives `stall`=0.
- Flush with hazard: same load-use stimulus plus `flush`=1 -> `stall`=0; EX receives a bubble after the edge; `ex_reg_write`=`ex_mem_write`=0.
- Pass-through: 8 back-to-back instructions, alu_op 000-111, no hazards -> each appears one cycle later with matching `alu_Op`, `alu_A`, `alu_B` and `ex_rd_addr`.
